// File: rtl/irq_agg_pkg.sv
// irq_agg_pkg: shared register addresses and field positions for the interrupt aggregator
package irq_agg_pkg;
  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd2;
  localparam logic [2:0] ADDR_VECTOR  = 3'd3;
  localparam logic [2:0] ADDR_FORCE   = 3'd4;
  localparam logic [2:0] ADDR_MODE    = 3'd5;
  localparam int MAX_SRC   = 16;
  localparam int VALID_BIT = 15;
  localparam int INDEX_W   = 4;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational priority encoder over the active interrupt sources
module irq_prio_enc
  import irq_agg_pkg::*;
#(
  parameter int N_SRC          = 8,
  parameter bit PRIO_LOW_FIRST = 1'b1
) (
  input  logic [N_SRC-1:0]   active,
  output logic               valid,
  output logic [INDEX_W-1:0] index
);
  // Scan from least to most important so the last hit is the winner.
  always_comb begin
    valid = |active;
    index = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (active[PRIO_LOW_FIRST ? i : N_SRC - 1 - i]) index = INDEX_W'(PRIO_LOW_FIRST ? i : N_SRC - 1 - i);
  end
endmodule

// File: rtl/irq_aggregator.sv
// irq_aggregator: Avalon-MM interrupt aggregator with pending latch, mask and priority encoding.
// Define IRQ_AGG_EDGE_EN to add the per-source MODE register for rising-edge detection.
module irq_aggregator
  import irq_agg_pkg::*;
#(
  parameter int N_SRC          = 8,
  parameter bit PRIO_LOW_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_SRC-1:0]   irq_in,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq,
  output logic [INDEX_W-1:0] irq_index
);
  if (N_SRC < 1 || N_SRC > MAX_SRC) begin : g_bad_n_src
    $error("irq_aggregator: N_SRC must be 1..16");
  end
  logic [N_SRC-1:0]   pending, mask, active, evt, set, clr, wd;
  logic               wr_en, valid, unused_wd;
  logic [INDEX_W-1:0] index;
  logic [15:0]        rd_next;
  assign wr_en     = chipselect && !write_n;
  assign wd        = writedata[N_SRC-1:0];
  assign unused_wd = ^writedata;
  assign active    = pending & mask;
`ifdef IRQ_AGG_EDGE_EN
  logic [N_SRC-1:0] mode, irq_in_d;
  // Edge-mode sources only fire on the cycle the line rises.
  assign evt = irq_in & ~(mode & irq_in_d);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mode     <= '0;
      irq_in_d <= '0;
    end else begin
      irq_in_d <= irq_in;
      if (wr_en && address == ADDR_MODE) mode <= wd;
    end
`else
  assign evt = irq_in;
`endif
  assign set = evt | ({N_SRC{wr_en && address == ADDR_FORCE}} & wd);
  assign clr = {N_SRC{wr_en && address == ADDR_PENDING}} & wd;
  irq_prio_enc #(.N_SRC(N_SRC), .PRIO_LOW_FIRST(PRIO_LOW_FIRST)) u_enc (
    .active(active),
    .valid (valid),
    .index (index)
  );
  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_PENDING: rd_next = 16'(pending);
      ADDR_MASK:    rd_next = 16'(mask);
      ADDR_ACTIVE:  rd_next = 16'(active);
      ADDR_VECTOR:  rd_next = {valid, 11'b0, index};
`ifdef IRQ_AGG_EDGE_EN
      ADDR_MODE:    rd_next = 16'(mode);
`endif
      default:      rd_next = '0;
    endcase
  end
  // A same-cycle set beats a W1C clear.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pending   <= '0;
      mask      <= '0;
      readdata  <= '0;
      irq       <= 1'b0;
      irq_index <= '0;
    end else begin
      pending   <= set | (pending & ~clr);
      if (wr_en && address == ADDR_MASK) mask <= wd;
      readdata  <= rd_next;
      irq       <= valid;
      irq_index <= index;
    end
endmodule
